// File: rtl/mux16_to_1_pkg.sv
// mux16_pkg: shared constants and lane-offset helper for the 16:1 registered selector.
// MUX16_TO_1_PIPE_EN selects the 2-cycle variant and sets LATENCY accordingly.
package mux16_pkg;
  localparam int N_IN  = 16;
  localparam int SEL_W = 4;
`ifdef MUX16_TO_1_PIPE_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 1;
`endif
  function automatic int LANE(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/mux16_to_1_mux21.sv
// mux21: combinational 2:1 leaf cell, f = s ? in1 : in0.
module mux21 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in0,
  input  logic             s,
  output logic [WIDTH-1:0] f
);
  assign f = s ? in1 : in0;
endmodule

// File: rtl/mux16_to_1.sv
// mux16_to_1: registered 1-of-16 lane selector built from a four-level mux21 tree.
// MUX16_TO_1_PIPE_EN inserts a register stage between levels 2 and 3 (latency 2).
module mux16_to_1
  import mux16_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid
);
  logic [7:0][WIDTH-1:0] w_l1;
  logic [3:0][WIDTH-1:0] w_l2;
  logic [3:0][WIDTH-1:0] w_l2q;
  logic [1:0][WIDTH-1:0] w_l3;
  logic [WIDTH-1:0]      w_l4;
  logic [1:0]            w_sel_hi;
  logic                  w_valid;
  genvar g;
  for (g = 0; g < 8; g++) begin : g_l1
    mux21 #(.WIDTH(WIDTH)) u_m (
      .in1(in[LANE(2*g+1, WIDTH) +: WIDTH]),
      .in0(in[LANE(2*g, WIDTH) +: WIDTH]),
      .s  (sel[0]),
      .f  (w_l1[g])
    );
  end
  for (g = 0; g < 4; g++) begin : g_l2
    mux21 #(.WIDTH(WIDTH)) u_m (
      .in1(w_l1[2*g+1]),
      .in0(w_l1[2*g]),
      .s  (sel[1]),
      .f  (w_l2[g])
    );
  end
`ifdef MUX16_TO_1_PIPE_EN
  logic [3:0][WIDTH-1:0] r_l2;
  logic [1:0]            r_sel_hi;
  logic                  r_valid_p;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_l2      <= '0;
      r_sel_hi  <= '0;
      r_valid_p <= 1'b0;
    end else begin
      r_l2      <= w_l2;
      r_sel_hi  <= sel[3:2];
      r_valid_p <= in_valid;
    end
  end
  assign w_l2q    = r_l2;
  assign w_sel_hi = r_sel_hi;
  assign w_valid  = r_valid_p;
`else
  assign w_l2q    = w_l2;
  assign w_sel_hi = sel[3:2];
  assign w_valid  = in_valid;
`endif
  for (g = 0; g < 2; g++) begin : g_l3
    mux21 #(.WIDTH(WIDTH)) u_m (
      .in1(w_l2q[2*g+1]),
      .in0(w_l2q[2*g]),
      .s  (w_sel_hi[0]),
      .f  (w_l3[g])
    );
  end
  mux21 #(.WIDTH(WIDTH)) u_l4 (
    .in1(w_l3[1]),
    .in0(w_l3[0]),
    .s  (w_sel_hi[1]),
    .f  (w_l4)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= w_l4;
      out_valid <= w_valid;
    end
  end
endmodule

// File: tb/tb_mux16_to_1.sv
// tb_mux16_to_1: directed self-checking bench for mux16_to_1 and the mux21 leaf cell.
module tb_mux16_to_1;
  import mux16_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] t_in = '0;
  logic [3:0]  t_sel = '0;
  logic        t_valid = 1'b0;
  logic        t_out;
  logic        t_out_valid;
  logic [3:0]  m_in1 = 4'b0101;
  logic [3:0]  m_in0 = 4'b1010;
  logic        m_s = 1'b0;
  logic [3:0]  m_f;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  mux16_to_1 #(.WIDTH(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (t_in),
    .sel      (t_sel),
    .in_valid (t_valid),
    .out      (t_out),
    .out_valid(t_out_valid)
  );
  mux21 #(.WIDTH(4)) u_leaf (
    .in1(m_in1),
    .in0(m_in0),
    .s  (m_s),
    .f  (m_f)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [15:0] i, input logic [3:0] s, input logic v);
    t_in    = i;
    t_sel   = s;
    t_valid = v;
  endtask
  task automatic settle();
    repeat (LATENCY) @(negedge clk);
  endtask
  logic [3:0] st_sel [8] = '{4'd1, 4'd3, 4'd4, 4'd9, 4'd13, 4'd14, 4'd15, 4'd0};
  logic       st_exp [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       st_vld [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    m_s = 1'b0;
    #1 chk("mux21_s0", m_f, 4'b1010);
    m_s = 1'b1;
    #1 chk("mux21_s1", m_f, 4'b0101);
    rst = 1'b1;
    drive(16'hffff, 4'd5, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("rst_out", t_out, 1'b0);
      chk("rst_valid", t_out_valid, 1'b0);
    end
    rst = 1'b0;
    for (int e = 0; e < LATENCY; e++) begin
      chk("release_pre_valid", t_out_valid, 1'b0);
      @(negedge clk);
    end
    chk("release_first_valid", t_out_valid, 1'b1);
    chk("release_first_out", t_out, 1'b1);
    drive(16'h3f0a, 4'd0, 1'b1); settle(); chk("dir_sel0", t_out, 1'b0);
    drive(16'h3f0a, 4'd2, 1'b1); settle(); chk("dir_sel2", t_out, 1'b0);
    drive(16'h3f0a, 4'd8, 1'b1); settle(); chk("dir_sel8", t_out, 1'b1);
    drive(16'h3f0a, 4'd15, 1'b1); settle(); chk("dir_sel15", t_out, 1'b0);
    chk("dir_valid", t_out_valid, 1'b1);
    for (int k = 0; k < 16; k++)
      for (int s = 0; s < 16; s++) begin
        drive(16'h1 << k, s[3:0], 1'b1);
        settle();
        chk("walk_one", t_out, (s == k) ? 1'b1 : 1'b0);
      end
    for (int k = 0; k < 16; k++)
      for (int s = 0; s < 16; s++) begin
        drive(~(16'h1 << k), s[3:0], 1'b1);
        settle();
        chk("walk_zero", t_out, (s == k) ? 1'b0 : 1'b1);
      end
    for (int i = 0; i < 8 + LATENCY; i++) begin
      if (i >= LATENCY) begin
        chk("stream_out", t_out, st_exp[i-LATENCY]);
        chk("stream_valid", t_out_valid, st_vld[i-LATENCY]);
      end
      if (i < 8) drive(16'h3f0a, st_sel[i], st_vld[i]);
      else drive(16'h0000, 4'd0, 1'b0);
      @(negedge clk);
    end
    drive(16'h3f0a, 4'd8, 1'b1);
    settle();
    chk("mid_pre_valid", t_out_valid, 1'b1);
    chk("mid_pre_out", t_out, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out", t_out, 1'b0);
    chk("mid_rst_valid", t_out_valid, 1'b0);
    rst = 1'b0;
    drive(16'h0000, 4'd0, 1'b0);
    repeat (LATENCY + 1) begin
      @(negedge clk);
      chk("mid_no_stale_valid", t_out_valid, 1'b0);
      chk("mid_no_stale_out", t_out, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
